// File: rtl/alu_rs_scheduler_if.sv
// Handshake bundle between decode / RS entries / ALU and the ALU reservation-station scheduler.
// Allocation is a one-cycle strobe: dispatchValid is accepted when writeRequests is non-zero; issue: grants fire only while fuReady is high.
interface alu_rs_scheduler_if #(
  parameter int RS  = 3,
  parameter int CNT = 2
);
  logic          clear;
  logic          dispatchValid;
  logic [RS:0]   selectReq;
  logic          fuReady;
  logic [RS:0]   writeRequests;
  logic [RS:0]   grants;
  logic          execute;
  logic          full;
  logic [CNT:0]  occupancy;

  modport master (
    output clear, dispatchValid, selectReq, fuReady,
    input  writeRequests, grants, execute, full, occupancy
  );

  modport slave (
    input  clear, dispatchValid, selectReq, fuReady,
    output writeRequests, grants, execute, full, occupancy
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// Allocation and oldest-first issue control for the ALU reservation station.
// age[i][j]=1 means entry j is older than entry i; a ready entry issues when no older ready entry exists.
module alu_rs_scheduler #(
  parameter int RS  = 3,
  parameter int CNT = 2
) (
  input  logic              clk,
  input  logic              globalResetN,
  alu_rs_scheduler_if.slave bus
);

  logic [RS:0]        valid;
  logic [RS:0][RS:0]  age;
  logic [RS:0][RS:0]  age_next;
  logic [RS:0]        valid_next;
  logic [RS:0]        free_sel;
  logic               free_found;
  logic [RS:0]        write_req;
  logic [RS:0]        req;
  logic [RS:0]        gnt;
  logic [CNT:0]       occ;
  logic               is_full;

  assign is_full = &valid;

  always_comb begin
    occ = '0;
    for (int i = 0; i <= RS; i++) begin
      occ = occ + {{CNT{1'b0}}, valid[i]};
    end
  end

  // Lowest free index wins; allocation looks only at pre-update valid.
  always_comb begin
    free_sel   = '0;
    free_found = 1'b0;
    for (int i = 0; i <= RS; i++) begin
      if (!valid[i] && !free_found) begin
        free_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  assign write_req = (bus.dispatchValid && !is_full && !bus.clear && globalResetN) ? free_sel : '0;

  assign req = bus.selectReq & valid;

  always_comb begin
    gnt = '0;
    for (int i = 0; i <= RS; i++) begin
      gnt[i] = bus.fuReady & ~bus.clear & req[i] & ~(|(req & age[i]));
    end
  end

  // New entry is younger than every currently valid entry; its column is wiped so reuse leaves no stale bits.
  always_comb begin
    age_next = age;
    for (int i = 0; i <= RS; i++) begin
      if (write_req[i]) begin
        for (int j = 0; j <= RS; j++) begin
          age_next[i][j] = (j != i) ? valid[j] : 1'b0;
        end
        for (int k = 0; k <= RS; k++) begin
          if (k != i) age_next[k][i] = 1'b0;
        end
      end
    end
  end

  assign valid_next = (valid & ~gnt) | write_req;

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      valid <= '0;
      age   <= '0;
    end else if (bus.clear) begin
      valid <= '0;
      age   <= '0;
    end else begin
      valid <= valid_next;
      age   <= age_next;
    end
  end

  assign bus.writeRequests = write_req;
  assign bus.grants        = gnt;
  assign bus.execute       = |gnt;
  assign bus.full          = is_full;
  assign bus.occupancy     = occ;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: allocation order, oldest-first issue, reuse, clear and async reset.
module tb_alu_rs_scheduler;

  logic clk;
  logic globalResetN;
  int   total;
  int   bad;

  alu_rs_scheduler_if #(.RS(3), .CNT(2)) bus ();

  alu_rs_scheduler #(.RS(3), .CNT(2)) dut (
    .clk          (clk),
    .globalResetN (globalResetN),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; outputs are sampled 1 ns later, well away from posedge.
  task automatic step(input logic dv, input logic [3:0] sel, input logic fr, input logic clr);
    @(negedge clk);
    bus.dispatchValid = dv;
    bus.selectReq     = sel;
    bus.fuReady       = fr;
    bus.clear         = clr;
    #1;
  endtask

  task automatic do_reset();
    globalResetN      = 1'b0;
    bus.dispatchValid = 1'b0;
    bus.selectReq     = 4'b0000;
    bus.fuReady       = 1'b0;
    bus.clear         = 1'b0;
    repeat (2) @(negedge clk);
    globalResetN = 1'b1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (bus.writeRequests !== 4'b0000) begin bad++; $display("FAIL reset_wr: got %b want 0000", bus.writeRequests); end
    total++; if (bus.grants !== 4'b0000) begin bad++; $display("FAIL reset_grants: got %b want 0000", bus.grants); end
    total++; if (bus.execute !== 1'b0) begin bad++; $display("FAIL reset_execute: got %b want 0", bus.execute); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_alloc();
    logic [3:0] exp_wr [5];
    exp_wr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0000, 1'b0, 1'b0);
      total++; if (bus.writeRequests !== exp_wr[k]) begin bad++; $display("FAIL alloc_wr[%0d]: got %b want %b", k, bus.writeRequests, exp_wr[k]); end
      total++; if (bus.occupancy !== 3'(k < 4 ? k : 4)) begin bad++; $display("FAIL alloc_occ[%0d]: got %0d want %0d", k, bus.occupancy, (k < 4 ? k : 4)); end
    end
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL alloc_full: got %b want 1", bus.full); end
  endtask

  task automatic test_issue_order();
    logic [3:0] exp_g [3];
    exp_g = '{4'b0010, 4'b0100, 4'b1000};
    do_reset();
    fill(4);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b1110, 1'b1, 1'b0);
      total++; if (bus.grants !== exp_g[k]) begin bad++; $display("FAIL issue_grant[%0d]: got %b want %b", k, bus.grants, exp_g[k]); end
      total++; if (bus.execute !== 1'b1) begin bad++; $display("FAIL issue_exec[%0d]: got %b want 1", k, bus.execute); end
      total++; if (bus.occupancy !== 3'(4 - k)) begin bad++; $display("FAIL issue_occ[%0d]: got %0d want %0d", k, bus.occupancy, 4 - k); end
    end
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    total++; if (bus.occupancy !== 3'd1) begin bad++; $display("FAIL issue_occ_end: got %0d want 1", bus.occupancy); end
  endtask

  task automatic test_fu_stall();
    do_reset();
    fill(2);
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    total++; if (bus.grants !== 4'b0000) begin bad++; $display("FAIL stall_grant: got %b want 0000", bus.grants); end
    total++; if (bus.writeRequests !== 4'b0100) begin bad++; $display("FAIL stall_wr: got %b want 0100", bus.writeRequests); end
    step(1'b0, 4'b0110, 1'b1, 1'b0);
    total++; if (bus.grants !== 4'b0010) begin bad++; $display("FAIL stall_after: got %b want 0010", bus.grants); end
    total++; if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL stall_occ: got %0d want 3", bus.occupancy); end
  endtask

  task automatic test_reuse();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    fill(4);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    total++; if (bus.grants !== 4'b0001) begin bad++; $display("FAIL reuse_first: got %b want 0001", bus.grants); end
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    total++; if (bus.writeRequests !== 4'b0001) begin bad++; $display("FAIL reuse_wr: got %b want 0001", bus.writeRequests); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b1111, 1'b1, 1'b0);
      total++; if (bus.grants !== exp_g[k]) begin bad++; $display("FAIL reuse_grant[%0d]: got %b want %b", k, bus.grants, exp_g[k]); end
    end
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reuse_occ: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(4);
    step(1'b1, 4'b0001, 1'b1, 1'b0);
    total++; if (bus.grants !== 4'b0001) begin bad++; $display("FAIL b2b_grant: got %b want 0001", bus.grants); end
    total++; if (bus.writeRequests !== 4'b0000) begin bad++; $display("FAIL b2b_wr_blocked: got %b want 0000", bus.writeRequests); end
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL b2b_full: got %b want 1", bus.full); end
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    total++; if (bus.writeRequests !== 4'b0001) begin bad++; $display("FAIL b2b_wr_next: got %b want 0001", bus.writeRequests); end
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL b2b_occ: got %0d want 4", bus.occupancy); end
  endtask

  task automatic test_clear();
    do_reset();
    fill(3);
    step(1'b1, 4'b1111, 1'b1, 1'b1);
    total++; if (bus.grants !== 4'b0000) begin bad++; $display("FAIL clear_grant: got %b want 0000", bus.grants); end
    total++; if (bus.writeRequests !== 4'b0000) begin bad++; $display("FAIL clear_wr: got %b want 0000", bus.writeRequests); end
    total++; if (bus.execute !== 1'b0) begin bad++; $display("FAIL clear_exec: got %b want 0", bus.execute); end
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL clear_occ: got %0d want 0", bus.occupancy); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL clear_full: got %b want 0", bus.full); end
    total++; if (bus.writeRequests !== 4'b0001) begin bad++; $display("FAIL clear_wr_next: got %b want 0001", bus.writeRequests); end
    step(1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    fill(3);
    step(1'b0, 4'b0001, 1'b1, 1'b0);
    total++; if (bus.grants !== 4'b0001) begin bad++; $display("FAIL areset_pre_grant: got %b want 0001", bus.grants); end
    total++; if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL areset_pre_occ: got %0d want 3", bus.occupancy); end
    #2;
    globalResetN = 1'b0;
    #1;
    total++; if (bus.grants !== 4'b0000) begin bad++; $display("FAIL areset_grant: got %b want 0000", bus.grants); end
    total++; if (bus.execute !== 1'b0) begin bad++; $display("FAIL areset_exec: got %b want 0", bus.execute); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL areset_occ: got %0d want 0", bus.occupancy); end
    bus.selectReq = 4'b0000;
    bus.fuReady   = 1'b0;
    @(negedge clk);
    globalResetN = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    globalResetN      = 1'b0;
    bus.dispatchValid = 1'b0;
    bus.selectReq     = 4'b0000;
    bus.fuReady       = 1'b0;
    bus.clear         = 1'b0;
    test_reset();
    test_alloc();
    test_issue_order();
    test_fu_stall();
    test_reuse();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Allocation and issue controller for the 4-entry ALU reservation station.
- Picks a free entry for each dispatched ALU instruction and drives the per-entry writeRequests vector.
- Tracks entry age with an age matrix and grants the single oldest ready entry to the ALU whenever the functional unit can accept work.
- Drives the RS entry grant lines and the execute strobe of the RS output register; handles pipeline flush.

Parameters:
- RS, 3, index MSB of the entry vectors; entry count is RS+1 (4).
- CNT, 2, MSB of the occupancy count (count range 0..RS+1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- globalResetN  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush (branch mispredict); empties the station.
- dispatchValid  input  1  decode has an ALU instruction to place this cycle.
- selectReq  input  RS+1  per-entry "operands ready" from RS entries.
- fuReady  input  1  ALU can accept an instruction this cycle.
- writeRequests  output  RS+1  one-hot allocation strobe to RS entries.
- grants  output  RS+1  one-hot issue grant to RS entries / srcMux select.
- execute  output  1  load RS output register; equals |grants.
- full  output  1  no free entry; decode must stall.
- occupancy  output  CNT+1  number of valid entries.

Behaviour:
- State:
  - valid[RS:0]: entry allocated and not yet issued.
  - age[RS:0][RS:0]: age[i][j]=1 means entry j is older than entry i.
- Reset (globalResetN low, asynchronous): valid=0, age=0. Consequently writeRequests=0, grants=0, execute=0, full=0, occupancy=0 while reset is held.
- full = &valid. occupancy = popcount(valid). Both are combinational from registered state.
- Allocation (combinational):
  - writeRequests = lowest-index i with valid[i]=0, gated by dispatchValid & !full & !clear.
  - Otherwise writeRequests = 0.
- Issue (combinational):
  - req = selectReq & valid.
  - grants[i] = fuReady & !clear & req[i] & no j with req[j] & age[i][j].
  - At most one grant per cycle. Zero-cycle select latency; the RS output register captures the operands on the same edge.
  - selectReq on non-valid entries is ignored.
- State update on rising edge:
  - Grant of entry i clears valid[i].
  - Allocation of entry i sets valid[i].
  - Allocation of entry i writes row i: age[i][j] = valid[j] for j≠i, and age[i][i]=0.
  - Allocation of entry i clears column i: age[k][i]=0 for all k≠i. This prevents a stale "older" bit from surviving entry reuse.
- Simultaneous events:
  - Grant and allocation in the same cycle: allocation uses the pre-update valid, so an entry freed this cycle cannot be reallocated until the next cycle. full therefore stays high for that cycle even if a grant is made.
  - A row written using a just-granted j may keep age[i][j]=1. This is harmless because j is no longer valid, and the bit is cleared when j is reallocated.
- clear:
  - writeRequests and grants are forced to 0 in the clear cycle.
  - Next cycle: valid=0 and age=0.
  - clear takes priority over all same-cycle allocation and issue.
- Reset mid-operation: state clears immediately and asynchronously; no in-flight grant survives.
- fuReady low: no grant; valid and age are held; allocation continues normally.

Test Plan:
1. Reset then 5 consecutive dispatchValid cycles, fuReady=0 -> writeRequests 0001, 0010, 0100, 1000, then 0000 with full=1. occupancy steps 1..4.
2. Fill 4 entries (alloc order 0,1,2,3), raise selectReq=1110 with fuReady=1 -> grants=0010 (entry 1 is oldest ready). Next cycle grants=0100, then 1000. occupancy falls to 1.
3. Entries 0..3 full; issue entry 0; reallocate it; then selectReq=1111 -> grants 0010, 0100, 1000, 0001 in that order (reused entry 0 is youngest).
4. full=1, fuReady=1, selectReq=0001, dispatchValid=1 -> grants=0001 and writeRequests=0000 in the same cycle. Next cycle writeRequests=0001, occupancy stays 4.
5. Three valid entries, clear=1 with dispatchValid=1 and selectReq=1111 -> grants=0 and writeRequests=0 in that cycle. Next cycle occupancy=0, full=0, and the first allocation goes to 0001.
6. globalResetN asserted low mid-cycle with occupancy=3 and a grant pending -> grants, execute, occupancy go to 0 without waiting for a clock edge.
